// File: rtl/alu_issue_pkg.sv
// Shared definitions for the LA32R ALU issue stage: one-hot ALU ops, opcode match values,
// the buffered entry layout and the buffer occupancy encoding.
package alu_issue_pkg;

  localparam int ALU_OP_W = 12;

  localparam int OP_ADD_BIT  = 0;
  localparam int OP_SUB_BIT  = 1;
  localparam int OP_SLT_BIT  = 2;
  localparam int OP_SLTU_BIT = 3;
  localparam int OP_AND_BIT  = 4;
  localparam int OP_NOR_BIT  = 5;
  localparam int OP_OR_BIT   = 6;
  localparam int OP_XOR_BIT  = 7;
  localparam int OP_SLL_BIT  = 8;
  localparam int OP_SRL_BIT  = 9;
  localparam int OP_SRA_BIT  = 10;
  localparam int OP_MOV_BIT  = 11;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 12'b1 << OP_ADD_BIT;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 12'b1 << OP_SUB_BIT;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 12'b1 << OP_SLT_BIT;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 12'b1 << OP_SLTU_BIT;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 12'b1 << OP_AND_BIT;
  localparam logic [ALU_OP_W-1:0] ALU_NOR  = 12'b1 << OP_NOR_BIT;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 12'b1 << OP_OR_BIT;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 12'b1 << OP_XOR_BIT;
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 12'b1 << OP_SLL_BIT;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 12'b1 << OP_SRL_BIT;
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = 12'b1 << OP_SRA_BIT;
  localparam logic [ALU_OP_W-1:0] ALU_MOV  = 12'b1 << OP_MOV_BIT;

  // Matched against inst[31:15]
  localparam logic [16:0] OPC_ADD_W  = 17'h00020;
  localparam logic [16:0] OPC_SUB_W  = 17'h00022;
  localparam logic [16:0] OPC_SLT    = 17'h00024;
  localparam logic [16:0] OPC_SLTU   = 17'h00025;
  localparam logic [16:0] OPC_NOR    = 17'h00028;
  localparam logic [16:0] OPC_AND    = 17'h00029;
  localparam logic [16:0] OPC_OR     = 17'h0002a;
  localparam logic [16:0] OPC_XOR    = 17'h0002b;
  localparam logic [16:0] OPC_SLL_W  = 17'h0002e;
  localparam logic [16:0] OPC_SRL_W  = 17'h0002f;
  localparam logic [16:0] OPC_SRA_W  = 17'h00030;
  localparam logic [16:0] OPC_SLLI_W = 17'h00081;
  localparam logic [16:0] OPC_SRLI_W = 17'h00089;
  localparam logic [16:0] OPC_SRAI_W = 17'h00091;

  localparam logic [9:0] OPC_ADDI_W  = 10'h00a;
  localparam logic [6:0] OPC_LU12I_W = 7'h0a;

  typedef struct packed {
    logic [ALU_OP_W-1:0] op;
    logic [31:0]         src1;
    logic [31:0]         src2;
    logic [4:0]          dest;
    logic                illegal;
  } alu_issue_entry_t;

  // Bit 0 = main register valid, bit 1 = skid register valid
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_ONE   = 2'b01,
    OCC_TWO   = 2'b11
  } occ_state_t;

endpackage

// File: rtl/alu_issue_if.sv
// Handshake and payload bundle between fetch/regfile read, the issue stage and the ALU.
// master = environment side, slave = the issue stage.
interface alu_issue_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_rj_value;
  logic [31:0] in_rk_value;

  logic        out_valid;
  logic        out_ready;
  logic [11:0] alu_op;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [4:0]  dest;
  logic        out_illegal;

  modport master (
    output in_valid, in_inst, in_rj_value, in_rk_value, out_ready,
    input  in_ready, out_valid, alu_op, alu_src1, alu_src2, dest, out_illegal
  );

  modport slave (
    input  in_valid, in_inst, in_rj_value, in_rk_value, out_ready,
    output in_ready, out_valid, alu_op, alu_src1, alu_src2, dest, out_illegal
  );

endinterface

// File: rtl/alu_issue_decode.sv
// Combinational LA32R integer decode into an ALU entry.
// Illegal flagging is only built when ALU_ISSUE_ILLEGAL_EN is defined.
module alu_issue_decode
  import alu_issue_pkg::*;
(
  input  logic [31:0]      inst,
  input  logic [31:0]      rj_value,
  input  logic [31:0]      rk_value,
  output alu_issue_entry_t entry
);

  logic [ALU_OP_W-1:0] op_3r;
  logic [ALU_OP_W-1:0] op_shift_imm;

  always_comb begin
    op_3r = '0;
    case (inst[31:15])
      OPC_ADD_W: op_3r = ALU_ADD;
      OPC_SUB_W: op_3r = ALU_SUB;
      OPC_SLT:   op_3r = ALU_SLT;
      OPC_SLTU:  op_3r = ALU_SLTU;
      OPC_NOR:   op_3r = ALU_NOR;
      OPC_AND:   op_3r = ALU_AND;
      OPC_OR:    op_3r = ALU_OR;
      OPC_XOR:   op_3r = ALU_XOR;
      OPC_SLL_W: op_3r = ALU_SLL;
      OPC_SRL_W: op_3r = ALU_SRL;
      OPC_SRA_W: op_3r = ALU_SRA;
      default:   op_3r = '0;
    endcase
  end

  always_comb begin
    op_shift_imm = '0;
    case (inst[31:15])
      OPC_SLLI_W: op_shift_imm = ALU_SLL;
      OPC_SRLI_W: op_shift_imm = ALU_SRL;
      OPC_SRAI_W: op_shift_imm = ALU_SRA;
      default:    op_shift_imm = '0;
    endcase
  end

  // The four formats occupy disjoint opcode ranges, so the priority order is irrelevant
  always_comb begin
    entry      = '0;
    entry.dest = inst[4:0];
    if (op_3r != '0) begin
      entry.op   = op_3r;
      entry.src1 = rj_value;
      entry.src2 = rk_value;
    end else if (op_shift_imm != '0) begin
      entry.op   = op_shift_imm;
      entry.src1 = rj_value;
      entry.src2 = {27'b0, inst[14:10]};
    end else if (inst[31:22] == OPC_ADDI_W) begin
      entry.op   = ALU_ADD;
      entry.src1 = rj_value;
      entry.src2 = {{20{inst[21]}}, inst[21:10]};
    end else if (inst[31:25] == OPC_LU12I_W) begin
      entry.op   = ALU_MOV;
      entry.src2 = {inst[24:5], 12'b0};
    end
`ifdef ALU_ISSUE_ILLEGAL_EN
    entry.illegal = (entry.op == '0);
`else
    entry.illegal = 1'b0;
`endif
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Registered ALU issue stage: decode in front of a two-entry (main + skid) FIFO buffer.
// Define ALU_ISSUE_ILLEGAL_EN to flag undecodable instructions on out_illegal.
module alu_issue_stage
  import alu_issue_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  alu_issue_if.slave  bus
);

  occ_state_t       state;
  occ_state_t       state_next;
  alu_issue_entry_t decoded;
  alu_issue_entry_t main_q;
  alu_issue_entry_t skid_q;

  logic accept;
  logic retire;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  alu_issue_decode u_decode (
    .inst     (bus.in_inst),
    .rj_value (bus.in_rj_value),
    .rk_value (bus.in_rk_value),
    .entry    (decoded)
  );

  assign accept = bus.in_valid & bus.in_ready;
  assign retire = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= OCC_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Flush wins over everything; with no loads asserted the buffered data is simply abandoned
  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_next = OCC_EMPTY;
    end else begin
      case (state)
        OCC_EMPTY: begin
          if (accept) begin
            state_next   = OCC_ONE;
            load_main_in = 1'b1;
          end
        end
        OCC_ONE: begin
          if (accept && retire) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            state_next = OCC_TWO;
            load_skid  = 1'b1;
          end else if (retire) begin
            state_next = OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          if (retire) begin
            state_next     = OCC_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_next = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in) begin
        main_q <= decoded;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= decoded;
      end
    end
  end

  // Both handshake outputs come straight from state bits, so in_ready never depends on out_ready
  assign bus.in_ready    = ~state[1];
  assign bus.out_valid   = state[0];
  assign bus.alu_op      = main_q.op;
  assign bus.alu_src1    = main_q.src1;
  assign bus.alu_src2    = main_q.src2;
  assign bus.dest        = main_q.dest;
  assign bus.out_illegal = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed test-plan vectors, backpressure/flush
// sequences and randomized traffic checked against an instruction-level reference decode.
module tb_alu_issue_stage;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  alu_issue_if bus ();

  alu_issue_stage dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] op;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [4:0]  dest;
    logic        ill;
  } exp_t;

`ifdef ALU_ISSUE_ILLEGAL_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   was_reset = 1'b1;

  int   r3_map[int];
  int   shi_map[int];
  int   r3_codes[11] = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h28, 32'h29,
                         32'h2a, 32'h2b, 32'h2e, 32'h2f, 32'h30};
  int   shi_codes[3] = '{32'h81, 32'h89, 32'h91};

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction-level reference: opcode tables map straight to op bit positions
  function automatic exp_t ref_decode(input logic [31:0] inst, input logic [31:0] rj,
                                      input logic [31:0] rk);
    exp_t e;
    int   opc;
    int   imm;
    e.op   = '0;
    e.s1   = '0;
    e.s2   = '0;
    e.dest = inst[4:0];
    e.ill  = 1'b0;
    opc    = int'(inst[31:15]);
    if (r3_map.exists(opc)) begin
      e.op = 12'(1 << r3_map[opc]);
      e.s1 = rj;
      e.s2 = rk;
    end else if (shi_map.exists(opc)) begin
      e.op = 12'(1 << shi_map[opc]);
      e.s1 = rj;
      e.s2 = 32'(inst[14:10]);
    end else if (inst[31:22] == 10'h00a) begin
      imm = int'(inst[21:10]);
      if (imm >= 2048) imm = imm - 4096;
      e.op = 12'h001;
      e.s1 = rj;
      e.s2 = 32'(imm);
    end else if (inst[31:25] == 7'h0a) begin
      e.op = 12'h800;
      e.s2 = 32'(inst[24:5]) * 32'd4096;
    end
    if (ILL_EN) e.ill = (e.op == 12'h000);
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    int          k;
    logic [31:0] r;
    logic [16:0] c;
    k = $urandom_range(0, 15);
    r = $urandom;
    if (k < 8) begin
      c = 17'(r3_codes[$urandom_range(0, 10)]);
      return {c, r[14:0]};
    end else if (k < 10) begin
      c = 17'(shi_codes[$urandom_range(0, 2)]);
      return {c, r[14:0]};
    end else if (k < 12) begin
      return {10'h00a, r[21:0]};
    end else if (k < 14) begin
      return {7'h0a, r[24:0]};
    end
    return r;
  endfunction

  task automatic apply_stimulus(input logic v, input logic [31:0] inst, input logic [31:0] rj,
                                input logic [31:0] rk);
    bus.in_valid    = v;
    bus.in_inst     = inst;
    bus.in_rj_value = rj;
    bus.in_rk_value = rk;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expects an empty buffer and out_ready=1; the entry retires on the edge after the check
  task automatic directed_one(input string name, input logic [31:0] inst, input logic [31:0] rj,
                              input logic [31:0] rk, input logic [11:0] op, input logic [31:0] s1,
                              input logic [31:0] s2, input logic [4:0] d, input logic ill);
    apply_stimulus(1'b1, inst, rj, rk);
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_output({name, "_valid"}, 128'(bus.out_valid), 128'(1'b1));
    check_output({name, "_op"}, 128'(bus.alu_op), 128'(op));
    check_output({name, "_src1"}, 128'(bus.alu_src1), 128'(s1));
    check_output({name, "_src2"}, 128'(bus.alu_src2), 128'(s2));
    check_output({name, "_dest"}, 128'(bus.dest), 128'(d));
    check_output({name, "_illegal"}, 128'(bus.out_illegal), 128'(ill));
    tick();
  endtask

  // Scoreboard feed: records each accepted instruction and forgets everything on flush/reset
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      #1;
      if (reset || flush) begin
        sb.delete();
      end else if (bus.in_valid && bus.in_ready) begin
        sb.push_back(ref_decode(bus.in_inst, bus.in_rj_value, bus.in_rk_value));
      end
    end
  end

  // Monitor: occupancy, head-of-queue contents and post-reset zeroing
  initial begin
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (was_reset) begin
        check_output("reset_outputs",
                     128'({bus.out_valid, bus.alu_op, bus.alu_src1, bus.alu_src2, bus.dest,
                           bus.out_illegal}), 128'(0));
      end
      check_output("out_valid_occupancy", 128'(bus.out_valid), 128'(sb.size() != 0));
      if (!reset) begin
        check_output("in_ready_occupancy", 128'(bus.in_ready), 128'(sb.size() < 2));
      end
      if (bus.out_valid && sb.size() != 0) begin
        e = sb[0];
        check_output("entry",
                     128'({bus.alu_op, bus.alu_src1, bus.alu_src2, bus.dest, bus.out_illegal}),
                     128'({e.op, e.s1, e.s2, e.dest, e.ill}));
        if (bus.out_ready && !flush && !reset) void'(sb.pop_front());
      end
      was_reset = reset;
    end
  end

  initial begin
    bit accepted;
    r3_map[32'h20] = 0;  r3_map[32'h22] = 1;  r3_map[32'h24] = 2;  r3_map[32'h25] = 3;
    r3_map[32'h29] = 4;  r3_map[32'h28] = 5;  r3_map[32'h2a] = 6;  r3_map[32'h2b] = 7;
    r3_map[32'h2e] = 8;  r3_map[32'h2f] = 9;  r3_map[32'h30] = 10;
    shi_map[32'h81] = 8; shi_map[32'h89] = 9; shi_map[32'h91] = 10;

    reset         = 1'b1;
    flush         = 1'b0;
    bus.out_ready = 1'b1;
    apply_stimulus(1'b0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_output("reset_in_ready", 128'(bus.in_ready), 128'(1'b1));
    tick();

    directed_one("add_w", 32'h00100C23, 32'd5, 32'd7, 12'h001, 32'd5, 32'd7, 5'd3, 1'b0);
    directed_one("slli_w", 32'h00409022, 32'hF, 32'h1234, 12'h100, 32'hF, 32'd4, 5'd2, 1'b0);
    directed_one("lu12i_w", 32'h142468A4, 32'hDEAD, 32'hBEEF, 12'h800, 32'd0, 32'h12345000,
                 5'd4, 1'b0);
    directed_one("addi_w", 32'h02BFFC25, 32'h10, 32'h0, 12'h001, 32'h10, 32'hFFFFFFFF, 5'd5,
                 1'b0);
    directed_one("zero_inst", 32'h00000000, 32'h55, 32'h66, 12'h000, 32'd0, 32'd0, 5'd0, ILL_EN);

    // Back-to-back stream with the consumer always ready
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1'b1, rand_inst(), $urandom, $urandom);
      @(negedge clk);
      check_output("stream_in_ready", 128'(bus.in_ready), 128'(1'b1));
      tick();
    end
    bus.in_valid = 1'b0;
    repeat (2) tick();

    // Backpressure: two accepted, the third held until space frees up
    bus.out_ready = 1'b0;
    apply_stimulus(1'b1, 32'h00100C23, 32'd1, 32'd2);
    tick();
    apply_stimulus(1'b1, 32'h00110C23, 32'd3, 32'd4);
    tick();
    apply_stimulus(1'b1, 32'h00120C23, 32'd5, 32'd6);
    @(negedge clk);
    check_output("bp_full_in_ready", 128'(bus.in_ready), 128'(1'b0));
    tick();
    @(negedge clk);
    check_output("bp_hold_in_ready", 128'(bus.in_ready), 128'(1'b0));
    check_output("bp_hold_out_valid", 128'(bus.out_valid), 128'(1'b1));
    tick();
    bus.out_ready = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 8 && !accepted; i++) begin
      @(negedge clk);
      if (bus.in_ready) accepted = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    check_output("bp_third_accepted", 128'(accepted), 128'(1'b1));
    repeat (3) tick();

    // Flush while full, with an instruction offered at the same time
    bus.out_ready = 1'b0;
    apply_stimulus(1'b1, rand_inst(), $urandom, $urandom);
    tick();
    apply_stimulus(1'b1, rand_inst(), $urandom, $urandom);
    tick();
    apply_stimulus(1'b1, rand_inst(), $urandom, $urandom);
    flush = 1'b1;
    @(negedge clk);
    check_output("flush_two_in_ready", 128'(bus.in_ready), 128'(1'b0));
    tick();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_output("flush_two_out_valid", 128'(bus.out_valid), 128'(1'b0));
    tick();

    // Flush in ONE drops the simultaneously offered instruction
    apply_stimulus(1'b1, rand_inst(), $urandom, $urandom);
    tick();
    apply_stimulus(1'b1, rand_inst(), $urandom, $urandom);
    flush = 1'b1;
    tick();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_output("flush_one_out_valid", 128'(bus.out_valid), 128'(1'b0));
    tick();

    // Random traffic with sporadic flushes and one mid-stream reset
    for (int c = 0; c < 600; c++) begin
      flush         = ($urandom_range(0, 39) == 0);
      reset         = (c == 300 || c == 301);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      apply_stimulus(1'($urandom_range(0, 1)), rand_inst(), $urandom, $urandom);
      tick();
    end
    flush         = 1'b0;
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    check_output("drain_queue_empty", 128'(sb.size()), 128'(0));
    check_output("drain_out_valid", 128'(bus.out_valid), 128'(1'b0));
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
